// File: rtl/mux4_2_pkg.sv
// rtl/mux4_2_pkg.sv - shared constants and types for the four-to-two lane merger
package mux4_2_pkg;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ACCEPT = 1'b0,
    SECOND = 1'b1
  } phase_e;

  // Replicated to WIDTH wherever an idle lane must drive all-zero data.
  localparam logic IDLE_DATA_BIT = 1'b0;

  function automatic logic any_valid(input logic [3:0] valids);
    return |valids;
  endfunction
endpackage

// File: rtl/mux4_2_if.sv
// rtl/mux4_2_if.sv - four-lane input side and two-lane output side of mux4_2
interface mux4_2_if
  import mux4_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             valid_in0;
  logic             valid_in1;
  logic             valid_in2;
  logic             valid_in3;
  logic             ready_in;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic             valid_out0;
  logic             valid_out1;
  logic             err_drop;

  modport master (
    output in0, in1, in2, in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    input  ready_in,
    input  out0, out1, valid_out0, valid_out1,
    input  err_drop
  );

  modport slave (
    input  in0, in1, in2, in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    output ready_in,
    output out0, out1, valid_out0, valid_out1,
    output err_drop
  );
endinterface

// File: rtl/mux_hold_reg.sv
// rtl/mux_hold_reg.sv - data+valid holding register with load enable and sync reset
module mux_hold_reg
  import mux4_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);
  logic [WIDTH:0] hold_q;
  logic [WIDTH:0] hold_d;

  // Invalid lanes are zeroed at capture so downstream never sees stale data.
  always_comb begin
    hold_d = hold_q;
    if (load) begin
      hold_d = d_valid ? {1'b1, d_data} : {1'b0, {WIDTH{IDLE_DATA_BIT}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign q_valid = hold_q[WIDTH];
  assign q_data  = hold_q[WIDTH-1:0];
endmodule

// File: rtl/mux4_2.sv
// rtl/mux4_2.sv - merges four lanes per two cycles onto a two-lane registered output
module mux4_2
  import mux4_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic     clk,
  input logic     reset,
  mux4_2_if.slave bus
);
  phase_e phase_q;
  phase_e phase_d;
  logic   err_drop_q;
  logic   err_drop_d;
  logic   accept;

  logic             h_valid [4];
  logic [WIDTH-1:0] h_data  [4];
  logic             s2_valid;
  logic             s3_valid;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] s3_data;

  assign accept = (phase_q == ACCEPT);

  always_comb begin
    phase_d    = accept ? SECOND : ACCEPT;
    err_drop_d = err_drop_q;
    if (!accept && any_valid({bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0})) begin
      err_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= ACCEPT;
      err_drop_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      err_drop_q <= err_drop_d;
    end
  end

  mux_hold_reg #(.WIDTH(WIDTH)) u_lane0 (
    .clk(clk), .reset(reset), .load(accept),
    .d_valid(bus.valid_in0), .d_data(bus.in0),
    .q_valid(h_valid[0]), .q_data(h_data[0])
  );
  mux_hold_reg #(.WIDTH(WIDTH)) u_lane1 (
    .clk(clk), .reset(reset), .load(accept),
    .d_valid(bus.valid_in1), .d_data(bus.in1),
    .q_valid(h_valid[1]), .q_data(h_data[1])
  );
  mux_hold_reg #(.WIDTH(WIDTH)) u_lane2 (
    .clk(clk), .reset(reset), .load(accept),
    .d_valid(bus.valid_in2), .d_data(bus.in2),
    .q_valid(h_valid[2]), .q_data(h_data[2])
  );
  mux_hold_reg #(.WIDTH(WIDTH)) u_lane3 (
    .clk(clk), .reset(reset), .load(accept),
    .d_valid(bus.valid_in3), .d_data(bus.in3),
    .q_valid(h_valid[3]), .q_data(h_data[3])
  );

  // Lanes 2/3 move to a second stage while the next group is being captured.
  mux_hold_reg #(.WIDTH(WIDTH)) u_stage2_lane2 (
    .clk(clk), .reset(reset), .load(!accept),
    .d_valid(h_valid[2]), .d_data(h_data[2]),
    .q_valid(s2_valid), .q_data(s2_data)
  );
  mux_hold_reg #(.WIDTH(WIDTH)) u_stage2_lane3 (
    .clk(clk), .reset(reset), .load(!accept),
    .d_valid(h_valid[3]), .d_data(h_data[3]),
    .q_valid(s3_valid), .q_data(s3_data)
  );

  assign bus.ready_in   = accept;
  assign bus.err_drop   = err_drop_q;
  assign bus.out0       = accept ? s2_data  : h_data[0];
  assign bus.out1       = accept ? s3_data  : h_data[1];
  assign bus.valid_out0 = accept ? s2_valid : h_valid[0];
  assign bus.valid_out1 = accept ? s3_valid : h_valid[1];
endmodule

// File: tb/tb_mux4_2.sv
// tb/tb_mux4_2.sv - scoreboard bench for mux4_2
module tb_mux4_2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux4_2_if #(.WIDTH(8)) bus ();

  mux4_2 #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] o0;
    logic [7:0] o1;
    logic       v0;
    logic       v1;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   m_accept = 1'b1;
  bit   m_err = 1'b0;
  bit   mon_en = 1'b0;

  function automatic exp_t pair(input logic va, input logic [7:0] da,
                                input logic vb, input logic [7:0] db);
    exp_t e;
    e.o0 = va ? da : 8'h00;
    e.v0 = va;
    e.o1 = vb ? db : 8'h00;
    e.v1 = vb;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update happens on the same edge the DUT samples its inputs.
  task automatic cycle(input logic rst, input logic [3:0] v,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    @(negedge clk);
    reset = rst;
    bus.in0 = d0; bus.in1 = d1; bus.in2 = d2; bus.in3 = d3;
    bus.valid_in0 = v[0]; bus.valid_in1 = v[1];
    bus.valid_in2 = v[2]; bus.valid_in3 = v[3];
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_accept = 1'b1;
      m_err = 1'b0;
    end else begin
      if (m_accept) begin
        exp_q.push_back(pair(v[0], d0, v[1], d1));
        exp_q.push_back(pair(v[2], d2, v[3], d3));
      end else if (v != 4'b0000) begin
        m_err = 1'b1;
      end
      m_accept = !m_accept;
    end
    mon_en = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 4'b0000, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic group(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    if (!m_accept) idle();
    cycle(1'b0, v, d0, d1, d2, d3);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (mon_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      a = {bus.out0, bus.out1, bus.valid_out0, bus.valid_out1};
      check("outputs", 32'(a), 32'(e));
      check("ready_in", 32'(bus.ready_in), 32'(m_accept));
      check("err_drop", 32'(bus.err_drop), 32'(m_err));
    end
  end

  initial begin
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.valid_in0 = 1'b0; bus.valid_in1 = 1'b0;
    bus.valid_in2 = 1'b0; bus.valid_in3 = 1'b0;

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    group(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    group(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int g = 0; g < 8; g++)
      group(4'b1111, 8'(4*g), 8'(4*g+1), 8'(4*g+2), 8'(4*g+3));

    group(4'b1010, 8'h11, 8'h22, 8'h33, 8'h44);

    for (int i = 0; i < 100; i++)
      group(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    group(4'b1111, 8'h55, 8'h55, 8'h55, 8'h55);
    cycle(1'b1, 4'b1111, 8'h55, 8'h55, 8'h55, 8'h55);
    for (int i = 0; i < 3; i++)
      group(4'b1111, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

    group(4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    cycle(1'b0, 4'b0010, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    for (int i = 0; i < 6; i++)
      group(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    cycle(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 4; i++) idle();
    @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
